uart_tx_arbiter: RTL

- Shares one byte-level UART transmitter between NUM_REQ independent message sources, e.g. a credits banner, a CPU debug port and a status reporter.
- Arbitration is round-robin at message granularity. A granted requester keeps the transmitter until it sends a byte flagged last.
- A programmable idle gap is inserted between messages.
- A watchdog takes the grant back from a requester that stalls mid-message.
- Sits between the message generators and the UART byte serializer (valid/ready byte interface).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiters.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_GAP_CYCLES     = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating-priority encoder: the first set request at or after ptr (mod N) wins.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any_req
);

  int idx;

  // Scan from the far end back toward ptr so the nearest request overwrites.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of one UART byte transmitter,
// with an idle gap between messages and a stall watchdog on the owner.
//
// state    | meaning
// ST_IDLE  | nobody owns the transmitter; arbitrate among valid requesters
// ST_GRANT | owner's byte stream is passed through to the serializer
// ST_GAP   | line held idle for GAP_CYCLES before the next arbitration
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic                        timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_TC    = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt, pick;
  logic [IDX_W-1:0]   owner_q, owner_nxt, rr_ptr, rr_ptr_nxt, pick_idx, owner_inc;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_nxt, wd_cnt, wd_cnt_nxt;
  logic               tp_nxt, any_req, owner_valid, xfer;

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign owner_inc   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_valid = (state == ST_GRANT) && req_valid[owner_q];
  assign xfer        = owner_valid && tx_ready;

  assign tx_valid  = owner_valid;
  assign tx_data   = (state == ST_GRANT) ? req_data[owner_q*BYTE_W +: BYTE_W] : '0;
  assign req_ready = ((state == ST_GRANT) && tx_ready) ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    owner_nxt   = owner_q;
    rr_ptr_nxt  = rr_ptr;
    gap_cnt_nxt = gap_cnt;
    wd_cnt_nxt  = wd_cnt;
    tp_nxt      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt  = ST_GRANT;
          grant_nxt  = pick;
          owner_nxt  = pick_idx;
          wd_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        // Only a low valid counts toward the watchdog; back-pressure never does.
        if (xfer && req_last[owner_q]) begin
          state_nxt   = ST_GAP;
          grant_nxt   = '0;
          rr_ptr_nxt  = owner_inc;
          gap_cnt_nxt = GAP_LOAD;
          wd_cnt_nxt  = '0;
        end else if (!req_valid[owner_q]) begin
          if (wd_cnt == WD_TC) begin
            state_nxt   = ST_GAP;
            grant_nxt   = '0;
            rr_ptr_nxt  = owner_inc;
            gap_cnt_nxt = GAP_LOAD;
            wd_cnt_nxt  = '0;
            tp_nxt      = 1'b1;
          end else begin
            wd_cnt_nxt = wd_cnt + 1'b1;
          end
        end else begin
          wd_cnt_nxt = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr        <= '0;
      gap_cnt       <= '0;
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant_q       <= grant_nxt;
      owner_q       <= owner_nxt;
      rr_ptr        <= rr_ptr_nxt;
      gap_cnt       <= gap_cnt_nxt;
      wd_cnt        <= wd_cnt_nxt;
      timeout_pulse <= tp_nxt;
    end
  end

endmodule
